significand_normalizer: RTL and testbench

//  Downstream of the exponent unpacker. Takes its outputs plus the raw 64-bit operand and builds
//  the significand 1.52. Denormals are normalized over several cycles, with the exponent adjusted
//  to match. Delivers an unpacked operand with class flags to the FPU core. Valid/ready on both sides.

---
 rtl/fpu_pkg.sv | 26 ++
 rtl/significand_normalizer_lzc.sv | 20 ++
 rtl/significand_normalizer.sv | 106 ++++++++++
 tb/tb_significand_normalizer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU front-end types: sequencing states, field widths and the unpacked operand record.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam int DBL_FRAC_W = 52;
    localparam int SGL_FRAC_W = 23;
    localparam int SIG_W      = 53;
    localparam int EXP_OUT_W  = 13;
    localparam int LZC_W      = 6;

    typedef struct packed {
        logic                 s;
        logic [EXP_OUT_W-1:0] e;
        logic [SIG_W-1:0]     f;
        logic                 zero;
        logic                 inf;
        logic                 nan;
        logic                 snan;
    } unpacked_t;

endpackage

// File: rtl/significand_normalizer_lzc.sv
// Leading-zero counter; an all-zero input reports W.
module lzc #(
    parameter int W = 53
) (
    input  logic [W-1:0] v,
    output logic [5:0]   count
);

    // NOTE: count gets a default before the loop so every path assigns it and no latch is inferred.
    always_comb begin
        count = 6'(W);
        // Ascending scan: the highest set bit is the last to overwrite the count.
        for (int i = 0; i < W; i++) begin
            if (v[i]) begin
                count = 6'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/significand_normalizer.sv
// Builds the 1.52 significand and class flags from a raw operand; denormals are
// normalized over several cycles, shifting at most MAX_SHIFT bits per cycle.
module significand_normalizer
    import fpu_pkg::*;
#(
    parameter int MAX_SHIFT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          fp,
    input  logic                 db,
    input  logic                 s,
    input  logic [10:0]          e,
    input  logic                 e_z,
    input  logic                 e_inf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 s_out,
    output logic [EXP_OUT_W-1:0] e_out,
    output logic [SIG_W-1:0]     f_out,
    output logic                 zero,
    output logic                 inf,
    output logic                 nan,
    output logic                 snan
);

    localparam logic [LZC_W-1:0] MAX_K = LZC_W'(MAX_SHIFT);

    state_e           state;
    state_e           state_next;
    unpacked_t        r;
    unpacked_t        load;
    logic             accept;
    logic             frac_nz;
    logic             quiet;
    logic             denorm;
    logic [LZC_W-1:0] lz;
    logic [LZC_W-1:0] k;

    lzc #(.W(SIG_W)) u_lzc (
        .v     (r.f),
        .count (lz)
    );

    assign in_ready = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    assign frac_nz = db ? (|fp[51:0]) : (|fp[54:32]);
    assign quiet   = db ? fp[51] : fp[54];
    assign denorm  = e_z & frac_nz;
    assign k       = (lz < MAX_K) ? lz : MAX_K;

    always_comb begin
        load      = '0;
        load.s    = s;
        load.e    = {{(EXP_OUT_W-11){e[10]}}, e};
        load.f    = db ? {~e_z, fp[51:0]} : {~e_z, fp[54:32], 29'b0};
        load.zero = e_z & ~frac_nz;
        load.inf  = e_inf & ~frac_nz;
        load.nan  = e_inf & frac_nz;
        load.snan = e_inf & frac_nz & ~quiet;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = IDLE;
            SHIFT:   if (lz <= MAX_K) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Acceptance covers both the idle start and the same-cycle handoff from DONE.
        if (accept) begin
            state_next = denorm ? SHIFT : DONE;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values together.
    // NOTE: the result record is cleared on reset because its fields drive the outputs directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r     <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                r <= load;
            end else if (state == SHIFT) begin
                r.f <= r.f << k;
                r.e <= r.e - {{(EXP_OUT_W-LZC_W){1'b0}}, k};
            end
        end
    end

    assign out_valid = (state == DONE);
    assign s_out     = r.s;
    assign e_out     = r.e;
    assign f_out     = r.f;
    assign zero      = r.zero;
    assign inf       = r.inf;
    assign nan       = r.nan;
    assign snan      = r.snan;

endmodule

// File: tb/tb_significand_normalizer.sv
// Self-checking bench: directed cases plus random operands against an arithmetic reference model.
module tb_significand_normalizer;

    localparam int MS = 16;

    typedef struct {
        logic        s;
        logic [12:0] e;
        logic [52:0] f;
        logic        zero;
        logic        inf;
        logic        nan;
        logic        snan;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] fp = '0;
    logic        db = 1'b0;
    logic        s = 1'b0;
    logic [10:0] e = '0;
    logic        e_z = 1'b0;
    logic        e_inf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        s_out;
    logic [12:0] e_out;
    logic [52:0] f_out;
    logic        zero;
    logic        inf;
    logic        nan;
    logic        snan;

    int total = 0;
    int bad   = 0;

    significand_normalizer #(.MAX_SHIFT(MS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp        (fp),
        .db        (db),
        .s         (s),
        .e         (e),
        .e_z       (e_z),
        .e_inf     (e_inf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_out     (s_out),
        .e_out     (e_out),
        .f_out     (f_out),
        .zero      (zero),
        .inf       (inf),
        .nan       (nan),
        .snan      (snan)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Plays the exponent unpacker too: derives s/e/e_z/e_inf from the raw operand.
    task automatic ref_model(input logic [63:0] v, input logic d, output logic ps,
                             output logic [10:0] pe, output logic pez, output logic peinf,
                             output exp_t x);
        int     field, bias, fmax, fw, eint, se, l;
        longint frac, sig;
        if (d) begin
            field = int'(v[62:52]); frac = longint'(v[51:0]);
            fw = 52; bias = 1023; fmax = 2047;
        end else begin
            field = int'(v[62:55]); frac = longint'(v[54:32]);
            fw = 23; bias = 127; fmax = 255;
        end
        ps    = v[63];
        pez   = (field == 0);
        peinf = (field == fmax);
        eint  = pez ? 1 - bias : field - bias;
        pe    = eint[10:0];
        se    = int'($signed(pe));
        sig   = (frac << (52 - fw)) + (pez ? 64'sd0 : (longint'(1) << 52));
        x.s    = v[63];
        x.zero = pez && frac == 0;
        x.inf  = peinf && frac == 0;
        x.nan  = peinf && frac != 0;
        x.snan = x.nan && ((frac >> (fw - 1)) & 1) == 0;
        l = 0;
        if (pez && frac != 0) begin
            while (sig < (longint'(1) << 52)) begin
                sig = sig * 2;
                l++;
            end
        end
        x.e   = 13'(se - l);
        x.f   = sig[52:0];
        x.lat = 1 + (l + MS - 1) / MS;
    endtask

    task automatic drive(input logic [63:0] v, input logic d, output exp_t x);
        logic ps, pez, peinf;
        logic [10:0] pe;
        ref_model(v, d, ps, pe, pez, peinf, x);
        fp = v; db = d; s = ps; e = pe; e_z = pez; e_inf = peinf;
    endtask

    task automatic check_out(input string tag, input exp_t x);
        check({tag, ".s"}, 64'(s_out), 64'(x.s));
        check({tag, ".e"}, 64'(e_out), 64'(x.e));
        check({tag, ".f"}, 64'(f_out), 64'(x.f));
        check({tag, ".flags"}, 64'({zero, inf, nan, snan}), 64'({x.zero, x.inf, x.nan, x.snan}));
    endtask

    // One operand from IDLE: accept, measure latency in cycles, check the result, drain.
    task automatic run_one(input logic [63:0] v, input logic d, input string tag);
        exp_t x;
        int   lat;
        drive(v, d, x);
        in_valid = 1'b1; out_ready = 1'b0;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(x.lat));
        check_out(tag, x);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".drain"}, 64'(out_valid), 64'd0);
    endtask

    function automatic logic [63:0] rand_op(input logic d);
        logic [63:0] v;
        logic [51:0] f52;
        logic [22:0] f23;
        int          cls;
        v   = {$urandom, $urandom};
        cls = int'($urandom_range(0, 4));
        f52 = 52'({$urandom, $urandom}) >> $urandom_range(0, 51);
        f23 = 23'($urandom) >> $urandom_range(0, 22);
        if (f52 == '0) f52 = 52'd1;
        if (f23 == '0) f23 = 23'd1;
        if (d) begin
            case (cls)
                0: v[62:0] = '0;
                1: v[62:0] = {11'h7FF, 52'd0};
                2: v[62:0] = {11'h7FF, f52};
                3: v[62:0] = {11'd0, f52};
                default: if (v[62:52] == 11'h7FF || v[62:52] == 11'd0) v[62:52] = 11'h3FF;
            endcase
        end else begin
            case (cls)
                0: v[62:32] = '0;
                1: v[62:32] = {8'hFF, 23'd0};
                2: v[62:32] = {8'hFF, f23};
                3: v[62:32] = {8'd0, f23};
                default: if (v[62:55] == 8'hFF || v[62:55] == 8'd0) v[62:55] = 8'h7F;
            endcase
        end
        return v;
    endfunction

    initial begin
        exp_t x1, x2, x3, x4, xd;
        logic d;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.in_ready", 64'(in_ready), 64'd0);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.outs", 64'({s_out, zero, inf, nan, snan}), 64'd0);
        check("rst.e", 64'(e_out), 64'd0);
        check("rst.f", 64'(f_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_one(64'h3FF0_0000_0000_0000, 1'b1, "one");
        run_one(64'h0000_0000_0000_0001, 1'b1, "dmin");
        run_one(64'h0000_0001_DEAD_BEEF, 1'b0, "smin");
        run_one(64'h7FF0_0000_0000_0001, 1'b1, "snan");
        run_one(64'h7FF8_0000_0000_0000, 1'b1, "qnan");
        run_one(64'h8000_0000_0000_0000, 1'b1, "nzero");
        run_one(64'hFFF0_0000_0000_0000, 1'b1, "ninf");
        run_one(64'h0008_0000_0000_0000, 1'b1, "dbig");

        // Back-to-back with handoff, then backpressure
        drive(64'h3FF0_0000_0000_0000, 1'b1, x1);
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("b2b.v1", 64'(out_valid), 64'd1);
        check("b2b.r1", 64'(in_ready), 64'd1);
        check_out("b2b.1", x1);
        drive(64'h4000_0000_0000_0000, 1'b1, x2);
        @(negedge clk);
        check("b2b.v2", 64'(out_valid), 64'd1);
        check_out("b2b.2", x2);
        drive(64'h4008_0000_0000_0000, 1'b1, x3);
        @(negedge clk);
        check("b2b.v3", 64'(out_valid), 64'd1);
        check_out("b2b.3", x3);
        drive(64'h4010_0000_0000_0000, 1'b1, x4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold.v", 64'(out_valid), 64'd1);
            check("hold.in_ready", 64'(in_ready), 64'd0);
            check_out("hold", x3);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("b2b.v4", 64'(out_valid), 64'd1);
        check_out("b2b.4", x4);
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b.idle", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Reset in the middle of a denormal shift
        drive(64'h0000_0000_0000_0001, 1'b1, xd);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("abort.pre", 64'(out_valid), 64'd0);
        rst = 1'b1;
        check("abort.in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("abort.v", 64'(out_valid), 64'd0);
        check("abort.outs", 64'({s_out, zero, inf, nan, snan}), 64'd0);
        check("abort.e", 64'(e_out), 64'd0);
        check("abort.f", 64'(f_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort.v2", 64'(out_valid), 64'd0);
        run_one(64'h3FF8_0000_0000_0000, 1'b1, "fresh");

        // Random operands
        for (int n = 0; n < 60; n++) begin
            d = 1'($urandom_range(0, 1));
            run_one(rand_op(d), d, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
